// File: rtl/iob_intr_rx_if.sv
// Bus bundle for iob_intr_rx.
// Carries the inbound NoC flit handshake, the decoded interrupt record
// handshake and the error counter. The slave modport is the receiver block;
// the master modport is the NoC source / record consumer side.
interface iob_intr_rx_if;
  logic        noc_in_val;
  logic        noc_in_rdy;
  logic [63:0] noc_in_data;
  logic        intr_val;
  logic        intr_rdy;
  logic [31:0] intr_tile;
  logic [2:0]  intr_thr;
  logic [5:0]  intr_vec;
  logic [15:0] err_cnt;

  modport slave (
    input  noc_in_val, noc_in_data, intr_rdy,
    output noc_in_rdy, intr_val, intr_tile, intr_thr, intr_vec, err_cnt
  );

  modport master (
    output noc_in_val, noc_in_data, intr_rdy,
    input  noc_in_rdy, intr_val, intr_tile, intr_thr, intr_vec, err_cnt
  );
endinterface

// File: rtl/iob_intr_rx.sv
// iob_intr_rx: NoC interrupt packet receiver.
// Parses inbound NoC packets (one header flit followed by `length` payload
// flits). Interrupt packets yield one decoded record (tile/thread/vector)
// taken from the first payload flit; records are queued in a small FIFO.
// Every other packet is drained and discarded.
// Optional feature: define IOB_RX_ERR_CNT_EN to build the saturating
// malformed-packet counter; otherwise err_cnt is tied to zero.
module iob_intr_rx #(
  parameter int          NOC_X_TILES = 3,
  parameter logic [7:0]  INTR_TYPE   = 8'd32,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  iob_intr_rx_if.slave   bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DRAIN   = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] tile;
    logic [2:0]  thr;
    logic [5:0]  vec;
  } rec_t;

  // Header fields (only meaningful when the flit is a header)
  logic [7:0] hdr_x, hdr_y, hdr_len, hdr_type;
  assign hdr_x    = bus.noc_in_data[49:42];
  assign hdr_y    = bus.noc_in_data[41:34];
  assign hdr_len  = bus.noc_in_data[29:22];
  assign hdr_type = bus.noc_in_data[21:14];

  // Header padding bits and upper payload bits carry nothing for this block.
  logic unused_data;
  assign unused_data = ^{bus.noc_in_data[63:50], bus.noc_in_data[33:30],
                         bus.noc_in_data[13:9]};

  state_e        state_q, state_d;
  logic [7:0]    rem_q, rem_d;
  logic [31:0]   tile_q, tile_d;

  rec_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  logic          empty, full;
  logic          flit_acc, pop, push;
  rec_t          push_rec, head;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign pop   = bus.intr_val && bus.intr_rdy;

  // Backpressure only when a record must be pushed into a full queue that is
  // not being popped this cycle; a same-cycle pop frees the slot in time.
  assign bus.noc_in_rdy = !((state_q == PAYLOAD) && full && !bus.intr_rdy);
  assign flit_acc       = bus.noc_in_val && bus.noc_in_rdy;

  assign push_rec.tile = tile_q;
  assign push_rec.thr  = bus.noc_in_data[8:6];
  assign push_rec.vec  = bus.noc_in_data[5:0];

  // Packet parser: next state, remaining-flit count, latched source tile
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tile_d  = tile_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (flit_acc) begin
          if ((hdr_type == INTR_TYPE) && (hdr_len != 8'd0)) begin
            state_d = PAYLOAD;
            rem_d   = hdr_len;
            tile_d  = 32'(hdr_y) * 32'(NOC_X_TILES) + 32'(hdr_x);
          end else if (hdr_len != 8'd0) begin
            state_d = DRAIN;
            rem_d   = hdr_len;
          end
        end
      end
      PAYLOAD: begin
        if (flit_acc) begin
          push = 1'b1;
          if (rem_q == 8'd1) begin
            state_d = IDLE;
            rem_d   = 8'd0;
          end else begin
            state_d = DRAIN;
            rem_d   = rem_q - 8'd1;
          end
        end
      end
      DRAIN: begin
        if (flit_acc) begin
          rem_d = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        rem_d   = 8'd0;
      end
    endcase
  end

  // Parser state register; reset drops any partial packet
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 8'd0;
      tile_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tile_q  <= tile_d;
    end
  end

  // Record storage; contents need no reset since outputs are masked when empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_rec;
  end

  // Queue pointers and occupancy; simultaneous push/pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop)  rd_q <= (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head          = mem_q[rd_q];
  assign bus.intr_val  = !empty;
  assign bus.intr_tile = empty ? 32'd0 : head.tile;
  assign bus.intr_thr  = empty ? 3'd0  : head.thr;
  assign bus.intr_vec  = empty ? 6'd0  : head.vec;

`ifdef IOB_RX_ERR_CNT_EN
  logic        hdr_err;
  logic [15:0] err_q;

  // A header is an error when it is not an interrupt or carries no payload
  assign hdr_err = flit_acc && (state_q == IDLE) &&
                   ((hdr_type != INTR_TYPE) || (hdr_len == 8'd0));

  // Saturating error counter bumped at header acceptance
  always_ff @(posedge clk) begin
    if (!rst_n)                            err_q <= 16'd0;
    else if (hdr_err && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
  end

  assign bus.err_cnt = err_q;
`else
  assign bus.err_cnt = 16'd0;
`endif

endmodule
